// File: rtl/base_pack_pkg.sv
// Shared types and helpers for the sparse-to-dense lane packer.
// Holds the FSM state encoding, the default lane-count type and slot indexing.
package base_pack_pkg;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

    localparam int unsigned DefWays     = 4;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefCntWidth = $clog2(DefWays + 1);

    typedef logic [DefCntWidth-1:0] lane_cnt_t;

    // Candidate slot of the k-th compressed incoming lane: it lands after the rc residual entries.
    function automatic int unsigned resid_slot(input int unsigned rc, input int unsigned k);
        return rc + k;
    endfunction

endpackage

// File: rtl/base_compress_align.sv
// Combinational compress-and-append: squeezes the valid lanes of a beat together and places
// them behind the residual entries, yielding 2*ways-1 candidate slots and the total count.
module base_compress_align
    import base_pack_pkg::*;
#(
    parameter int unsigned ways      = DefWays,
    parameter int unsigned width     = DefWidth,
    parameter int unsigned cnt_width = $clog2(ways + 1),
    parameter int unsigned tot_width = $clog2(2 * ways)
) (
    input  logic [ways-1:0]                en_i,
    input  logic [ways*width-1:0]          d_i,
    input  logic [(ways-1)*width-1:0]      resid_i,
    input  logic [cnt_width-1:0]           rc_i,
    output logic [(2*ways-1)*width-1:0]    slots_o,
    output logic [tot_width-1:0]           total_o
);

    logic [ways-1:0][tot_width-1:0]   pre;
    logic [tot_width-1:0]             acc;
    logic [2*ways-2:0][width-1:0]     slots;

    // Count-encode: pre[l] is the number of enabled lanes below lane l.
    always_comb begin
        acc = '0;
        pre = '0;
        for (int l = 0; l < ways; l++) begin
            pre[l] = acc;
            acc    = acc + tot_width'(en_i[l]);
        end
    end

    always_comb begin
        slots = '0;
        for (int k = 0; k < ways - 1; k++) begin
            if (k < int'(rc_i)) begin
                slots[k] = resid_i[k*width +: width];
            end
        end
        // Residual slots (< rc) and incoming slots (>= rc) never overlap.
        for (int l = 0; l < ways; l++) begin
            for (int s = 0; s < 2 * ways - 1; s++) begin
                if (en_i[l] && int'(resid_slot(int'(rc_i), int'(pre[l]))) == s) begin
                    slots[s] = d_i[l*width +: width];
                end
            end
        end
    end

    assign slots_o = slots;
    assign total_o = tot_width'(rc_i) + acc;

endmodule

// File: rtl/base_compress_pack.sv
// Streaming packer: accepts sparse lane beats, keeps up to ways-1 leftover entries and emits
// dense beats of exactly ways entries in arrival order; a flush pushes out the final partial beat.
module base_compress_pack
    import base_pack_pkg::*;
#(
    parameter int unsigned ways      = DefWays,
    parameter int unsigned width     = DefWidth,
    parameter int unsigned cnt_width = $clog2(ways + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [ways-1:0]        i_en,
    input  logic [ways*width-1:0]  i_d,
    input  logic                   i_flush,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [ways*width-1:0]  o_d,
    output logic [cnt_width-1:0]   o_cnt,
    output logic                   o_last
);

    localparam int unsigned TotWidth = $clog2(2 * ways);
    localparam logic [TotWidth-1:0] WaysT = TotWidth'(ways);

    state_e                      state_q, state_d;
    logic [cnt_width-1:0]        rc_q, rc_d;
    logic [(ways-1)*width-1:0]   resid_q, resid_d;
    logic                        o_v_q, o_v_d;
    logic [ways*width-1:0]       o_d_q, o_d_d;
    logic [cnt_width-1:0]        o_cnt_q, o_cnt_d;
    logic                        o_last_q, o_last_d;

    logic [(2*ways-1)*width-1:0] slots;
    logic [TotWidth-1:0]         total;
    logic                        out_free;
    logic                        accept;

    base_compress_align #(
        .ways      (ways),
        .width     (width),
        .cnt_width (cnt_width),
        .tot_width (TotWidth)
    ) u_align (
        .en_i    (i_en),
        .d_i     (i_d),
        .resid_i (resid_q),
        .rc_i    (rc_q),
        .slots_o (slots),
        .total_o (total)
    );

    assign out_free = ~o_v_q | o_r;
    assign i_r      = (state_q == StRun) & out_free;
    assign accept   = i_v & i_r;

    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        resid_d  = resid_q;
        o_v_d    = o_v_q;
        o_d_d    = o_d_q;
        o_cnt_d  = o_cnt_q;
        o_last_d = o_last_q;

        // A drained register is cleared so no stale lanes survive into a later load.
        if (out_free) begin
            o_v_d    = 1'b0;
            o_d_d    = '0;
            o_cnt_d  = '0;
            o_last_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (i_flush && (total <= WaysT)) begin
                        o_v_d    = 1'b1;
                        o_d_d    = slots[ways*width-1:0];
                        o_cnt_d  = cnt_width'(total);
                        o_last_d = 1'b1;
                        rc_d     = '0;
                        resid_d  = '0;
                    end else if (total >= WaysT) begin
                        o_v_d    = 1'b1;
                        o_d_d    = slots[ways*width-1:0];
                        o_cnt_d  = cnt_width'(ways);
                        o_last_d = 1'b0;
                        rc_d     = cnt_width'(total - WaysT);
                        resid_d  = slots[(2*ways-1)*width-1:ways*width];
                        if (i_flush) begin
                            state_d = StDrain;
                        end
                    end else begin
                        rc_d    = cnt_width'(total);
                        resid_d = slots[(ways-1)*width-1:0];
                    end
                end
            end
            StDrain: begin
                if (out_free) begin
                    o_v_d    = 1'b1;
                    o_d_d    = {{width{1'b0}}, resid_q};
                    o_cnt_d  = rc_q;
                    o_last_d = 1'b1;
                    rc_d     = '0;
                    resid_d  = '0;
                    state_d  = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StRun;
            rc_q     <= '0;
            resid_q  <= '0;
            o_v_q    <= 1'b0;
            o_d_q    <= '0;
            o_cnt_q  <= '0;
            o_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
            resid_q  <= resid_d;
            o_v_q    <= o_v_d;
            o_d_q    <= o_d_d;
            o_cnt_q  <= o_cnt_d;
            o_last_q <= o_last_d;
        end
    end

    assign o_v    = o_v_q;
    assign o_d    = o_d_q;
    assign o_cnt  = o_cnt_q;
    assign o_last = o_last_q;

endmodule
